odo_ctrl: RTL and testbench

//   Key-press-driven controller for the odometer display datapath. Holds a 3-digit BCD total

---
 rtl/odo_ctrl_pkg.sv | 34 +++
 rtl/odo_ctrl_bcd_inc3.sv | 37 +++
 rtl/odo_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_odo_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/odo_ctrl_pkg.sv
// Shared types and codes for the odometer controller.
// Mode and state encodings, BCD limits, 3-digit BCD bundle, digit clamp.
package odo_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT    = 2'b00,
    MODE_TRIP_CLR = 2'b01,
    MODE_SET      = 2'b10,
    MODE_HOLD     = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SET_U = 2'd1,
    ST_SET_T = 2'd2,
    ST_SET_H = 2'd3
  } state_e;

  localparam logic [3:0]  BCD_MAX  = 4'd9;
  localparam logic [11:0] BCD3_MAX = 12'h999;

  typedef struct packed {
    logic [3:0] huns;
    logic [3:0] tens;
    logic [3:0] units;
  } bcd3_t;

  function automatic logic [3:0] clamp_bcd(
    input logic [3:0] x
  );
    return (x > BCD_MAX) ? BCD_MAX : x;
  endfunction

endpackage

// File: rtl/odo_ctrl_bcd_inc3.sv
// bcd_inc3: combinational 3-digit BCD +1.
// Ports: d (12b BCD in), q (d+1, wraps 999->000), carry_out (d was 999).
module bcd_inc3
  import odo_ctrl_pkg::*;
(
  input  logic [11:0] d,
  output logic [11:0] q,
  output logic        carry_out
);

  bcd3_t di;
  bcd3_t qo;
  logic  c_u;
  logic  c_t;
  logic  c_h;

  assign di = bcd3_t'(d);

  always_comb begin
    c_u = (di.units == BCD_MAX);
    c_t = c_u && (di.tens == BCD_MAX);
    c_h = c_t && (di.huns == BCD_MAX);

    qo       = di;
    qo.units = c_u ? 4'd0 : di.units + 4'd1;
    if (c_u) begin
      qo.tens = c_t ? 4'd0 : di.tens + 4'd1;
    end
    if (c_t) begin
      qo.huns = c_h ? 4'd0 : di.huns + 4'd1;
    end
  end

  assign q         = qo;
  assign carry_out = c_h;

endmodule

// File: rtl/odo_ctrl.sv
// odo_ctrl: key-press driven odometer/trip controller with digit preset.
// Ports: clk_key1 (press), rst_n_key0 (async low), mode_sw, digit_sw,
//   tot_* / trip_* BCD digits, state_o, tot_ovf, trip_alarm.
// Optional: ODO_TRIP_ALARM_EN builds the registered trip_alarm compare.
module odo_ctrl
  import odo_ctrl_pkg::*;
#(
  parameter bit          WRAP_TOTAL = 1'b1,
  parameter logic [11:0] TRIP_LIMIT = 12'h100
) (
  input  logic       clk_key1,
  input  logic       rst_n_key0,
  input  logic [1:0] mode_sw,
  input  logic [3:0] digit_sw,
  output logic [3:0] tot_units,
  output logic [3:0] tot_tens,
  output logic [3:0] tot_huns,
  output logic [3:0] trip_units,
  output logic [3:0] trip_tens,
  output logic [3:0] trip_huns,
  output logic [1:0] state_o,
  output logic       tot_ovf,
  output logic       trip_alarm
);

  if ((TRIP_LIMIT[3:0] > BCD_MAX) ||
      (TRIP_LIMIT[7:4] > BCD_MAX) ||
      (TRIP_LIMIT[11:8] > BCD_MAX)) begin : g_lim_chk
    $error("TRIP_LIMIT must be BCD");
  end

  state_e state_q;
  state_e state_d;
  mode_e  mode;
  bcd3_t  tot_q;
  bcd3_t  tot_d;
  bcd3_t  trip_q;
  bcd3_t  trip_d;
  logic   ovf_q;
  logic   ovf_d;

  logic   cnt_ev;
  logic   clr_ev;
  logic   ld_u;
  logic   ld_t;
  logic   ld_h;
  logic   abort;

  logic [11:0] tot_inc;
  logic [11:0] trip_inc;
  logic        tot_c;
  logic        trip_c;
  logic [3:0]  dig;

  assign mode = mode_e'(mode_sw);
  assign dig  = clamp_bcd(digit_sw);

  bcd_inc3 u_inc_tot (
    .d         (tot_q),
    .q         (tot_inc),
    .carry_out (tot_c)
  );

  bcd_inc3 u_inc_trip (
    .d         (trip_q),
    .q         (trip_inc),
    .carry_out (trip_c)
  );

  always_ff @(posedge clk_key1 or negedge rst_n_key0) begin
    if (!rst_n_key0) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // HOLD in any SET state aborts; other modes load and advance.
  always_comb begin
    state_d = state_q;
    cnt_ev  = 1'b0;
    clr_ev  = 1'b0;
    ld_u    = 1'b0;
    ld_t    = 1'b0;
    ld_h    = 1'b0;
    abort   = (mode == MODE_HOLD);
    unique case (state_q)
      ST_RUN: begin
        unique case (mode)
          MODE_COUNT:    cnt_ev  = 1'b1;
          MODE_TRIP_CLR: clr_ev  = 1'b1;
          MODE_SET:      state_d = ST_SET_U;
          MODE_HOLD:     state_d = ST_RUN;
        endcase
      end
      ST_SET_U: begin
        if (abort) begin
          state_d = ST_RUN;
        end else begin
          ld_u    = 1'b1;
          state_d = ST_SET_T;
        end
      end
      ST_SET_T: begin
        if (abort) begin
          state_d = ST_RUN;
        end else begin
          ld_t    = 1'b1;
          state_d = ST_SET_H;
        end
      end
      ST_SET_H: begin
        state_d = ST_RUN;
        if (!abort) begin
          ld_h   = 1'b1;
          clr_ev = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    tot_d  = tot_q;
    trip_d = trip_q;
    ovf_d  = ovf_q;
    if (cnt_ev) begin
      tot_d  = (tot_c && !WRAP_TOTAL) ? bcd3_t'(BCD3_MAX)
                                      : bcd3_t'(tot_inc);
      trip_d = bcd3_t'(trip_inc);
      ovf_d  = ovf_q | tot_c;
    end
    if (ld_u) tot_d.units = dig;
    if (ld_t) tot_d.tens  = dig;
    if (ld_h) begin
      tot_d.huns = dig;
      ovf_d      = 1'b0;
    end
    if (clr_ev) trip_d = '0;
  end

  always_ff @(posedge clk_key1 or negedge rst_n_key0) begin
    if (!rst_n_key0) begin
      tot_q  <= '0;
      trip_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      tot_q  <= tot_d;
      trip_q <= trip_d;
      ovf_q  <= ovf_d;
    end
  end

`ifdef ODO_TRIP_ALARM_EN
  logic alarm_q;
  logic alarm_d;

  // BCD ordering matches binary ordering, so a plain compare works.
  // A trip wrap only feeds cnt_ev, so it never clears the flag.
  always_comb begin
    alarm_d = alarm_q;
    if (cnt_ev && (trip_inc >= TRIP_LIMIT)) alarm_d = 1'b1;
    if (clr_ev) alarm_d = 1'b0;
  end

  always_ff @(posedge clk_key1 or negedge rst_n_key0) begin
    if (!rst_n_key0) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign trip_alarm = alarm_q;
`else
  assign trip_alarm = 1'b0;
`endif

  assign tot_units  = tot_q.units;
  assign tot_tens   = tot_q.tens;
  assign tot_huns   = tot_q.huns;
  assign trip_units = trip_q.units;
  assign trip_tens  = trip_q.tens;
  assign trip_huns  = trip_q.huns;
  assign state_o    = state_q;
  assign tot_ovf    = ovf_q;

  logic unused_trip_c;
  assign unused_trip_c = trip_c;

endmodule

// File: tb/tb_odo_ctrl.sv
// tb_odo_ctrl: directed checks of odo_ctrl (wrapping and saturating).
// Each key press is one clk_key1 pulse; outputs sampled with clock low.
module tb_odo_ctrl;

`ifdef ODO_TRIP_ALARM_EN
  localparam logic [11:0] LIM      = 12'h010;
  localparam bit          ALARM_ON = 1'b1;
`else
  localparam logic [11:0] LIM      = 12'h100;
  localparam bit          ALARM_ON = 1'b0;
`endif

  logic       clk_key1;
  logic       rst_n_key0;
  logic [1:0] mode_sw;
  logic [3:0] digit_sw;

  logic [3:0] tu, tt, th, ru, rt, rh;
  logic [1:0] st;
  logic       ovf, alarm;

  logic [3:0] s_tu, s_tt, s_th, s_ru, s_rt, s_rh;
  logic [1:0] s_st;
  logic       s_ovf, s_alarm;

  int checks   = 0;
  int failures = 0;

  odo_ctrl #(.WRAP_TOTAL(1'b1), .TRIP_LIMIT(LIM)) u_dut (
    .clk_key1   (clk_key1),
    .rst_n_key0 (rst_n_key0),
    .mode_sw    (mode_sw),
    .digit_sw   (digit_sw),
    .tot_units  (tu),
    .tot_tens   (tt),
    .tot_huns   (th),
    .trip_units (ru),
    .trip_tens  (rt),
    .trip_huns  (rh),
    .state_o    (st),
    .tot_ovf    (ovf),
    .trip_alarm (alarm)
  );

  odo_ctrl #(.WRAP_TOTAL(1'b0), .TRIP_LIMIT(LIM)) u_sat (
    .clk_key1   (clk_key1),
    .rst_n_key0 (rst_n_key0),
    .mode_sw    (mode_sw),
    .digit_sw   (digit_sw),
    .tot_units  (s_tu),
    .tot_tens   (s_tt),
    .tot_huns   (s_th),
    .trip_units (s_ru),
    .trip_tens  (s_rt),
    .trip_huns  (s_rh),
    .state_o    (s_st),
    .tot_ovf    (s_ovf),
    .trip_alarm (s_alarm)
  );

  wire [11:0] tot   = {th, tt, tu};
  wire [11:0] trip  = {rh, rt, ru};
  wire [11:0] s_tot = {s_th, s_tt, s_tu};

  task automatic press(input int n);
    for (int i = 0; i < n; i++) begin
      #5 clk_key1 = 1'b1;
      #5 clk_key1 = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [11:0] obs,
                     input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    clk_key1   = 1'b0;
    rst_n_key0 = 1'b0;
    mode_sw    = 2'b00;
    digit_sw   = 4'd0;
    #3;
    chk("rst_tot", tot, 12'h000);
    chk("rst_trip", trip, 12'h000);
    chk("rst_state", {10'b0, st}, 12'd0);
    chk("rst_ovf", {11'b0, ovf}, 12'd0);
    chk("rst_alarm", {11'b0, alarm}, 12'd0);
    rst_n_key0 = 1'b1;
    #2;

    press(12);
    chk("cnt12_tot", tot, 12'h012);
    chk("cnt12_trip", trip, 12'h012);
    chk("cnt12_state", {10'b0, st}, 12'd0);
    chk("cnt12_ovf", {11'b0, ovf}, 12'd0);

    mode_sw = 2'b10;
    press(1);
    chk("set_enter", {10'b0, st}, 12'd1);
    chk("set_enter_tot", tot, 12'h012);
    digit_sw = 4'd7;
    press(1);
    chk("set_u_state", {10'b0, st}, 12'd2);
    chk("set_u_tot", tot, 12'h017);
    digit_sw = 4'd15;
    press(1);
    chk("set_t_clamp", tot, 12'h097);
    chk("set_t_state", {10'b0, st}, 12'd3);
    digit_sw = 4'd3;
    press(1);
    chk("set_h_tot", tot, 12'h397);
    chk("set_h_trip", trip, 12'h000);
    chk("set_h_state", {10'b0, st}, 12'd0);
    chk("set_h_sat", s_tot, 12'h397);

    press(1);
    digit_sw = 4'd8;
    press(1);
    digit_sw = 4'd9;
    press(2);
    chk("pre998", tot, 12'h998);
    mode_sw = 2'b00;
    press(3);
    chk("wrap_tot", tot, 12'h001);
    chk("wrap_ovf", {11'b0, ovf}, 12'd1);
    chk("wrap_trip", trip, 12'h003);
    chk("sat_tot", s_tot, 12'h999);
    chk("sat_ovf", {11'b0, s_ovf}, 12'd1);

    mode_sw = 2'b01;
    press(1);
    chk("clr_trip", trip, 12'h000);
    chk("clr_tot", tot, 12'h001);
    mode_sw = 2'b00;
    press(45);
    chk("t45_trip", trip, 12'h045);
    chk("t45_tot", tot, 12'h046);
    mode_sw = 2'b01;
    press(1);
    chk("clr45_trip", trip, 12'h000);
    chk("clr45_tot", tot, 12'h046);
    mode_sw = 2'b11;
    press(5);
    chk("hold_tot", tot, 12'h046);
    chk("hold_trip", trip, 12'h000);
    chk("hold_state", {10'b0, st}, 12'd0);
    chk("hold_ovf", {11'b0, ovf}, 12'd1);

    mode_sw = 2'b10;
    press(1);
    digit_sw = 4'd4;
    press(1);
    chk("abt_mid", {10'b0, st}, 12'd2);
    mode_sw = 2'b11;
    press(1);
    chk("abt_state", {10'b0, st}, 12'd0);
    chk("abt_tot", tot, 12'h044);

    mode_sw = 2'b10;
    press(1);
    digit_sw = 4'd5;
    press(1);
    chk("midset_state", {10'b0, st}, 12'd2);
    #2 rst_n_key0 = 1'b0;
    #1;
    chk("arst_tot", tot, 12'h000);
    chk("arst_trip", trip, 12'h000);
    chk("arst_state", {10'b0, st}, 12'd0);
    chk("arst_ovf", {11'b0, ovf}, 12'd0);
    chk("arst_sat", s_tot, 12'h000);
    #2 rst_n_key0 = 1'b1;
    #2;

    mode_sw = 2'b00;
    press(9);
    chk("al9_trip", trip, 12'h009);
    chk("al9", {11'b0, alarm}, 12'd0);
    press(1);
    chk("al10_trip", trip, 12'h010);
    chk("al10", {11'b0, alarm}, {11'b0, ALARM_ON});
    mode_sw = 2'b01;
    press(1);
    chk("al_clr", {11'b0, alarm}, 12'd0);
    chk("al_clr_trip", trip, 12'h000);
    mode_sw = 2'b00;
    press(15);
    chk("al15", {11'b0, alarm}, {11'b0, ALARM_ON});
    press(985);
    chk("trip_wrap", trip, 12'h000);
    chk("al_wrap", {11'b0, alarm}, {11'b0, ALARM_ON});
    chk("tot_1010", tot, 12'h010);
    chk("ovf_1010", {11'b0, ovf}, 12'd1);
    chk("sat_1010", s_tot, 12'h999);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
